// File: rtl/axi_slave_pkg.sv
// Shared state encoding, AXI response codes and address decode for the
// AXI4-Lite memory slave.
package axi_slave_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD_LAT = 3'd1,
      S_R      = 3'd2,
      S_WR_W   = 3'd3,
      S_WR_LAT = 3'd4,
      S_B      = 3'd5
   } SLV_STATE;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Wrong top byte is SLVERR; any address bit above the array is DECERR.
   function automatic logic [1:0] decode_resp(input logic [31:0] addr,
                                              input logic [7:0]  base_hi,
                                              input int unsigned idx_w);
      logic [23:0] w_above;
      w_above = addr[23:0] >> (idx_w + 32'd2);
      if (addr[31:24] != base_hi) return RESP_SLVERR;
      if (w_above != 24'd0)       return RESP_DECERR;
      return RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_slave_mem_array.sv
// DEPTH x 32 word store: synchronous write, asynchronous read on a shared index.
module axi_slave_mem_array #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned IDX_W = 8
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_addr,
   input  logic [31:0]      i_wdata,
   output logic [31:0]      o_rdata_c
);

   logic [31:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end

   assign o_rdata_c = r_mem[i_addr];

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave memory model serving one transaction at a time with
// programmable read/write response latency.
module axi_lite_mem_slave
   import axi_slave_pkg::*;
#(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned RD_LAT  = 2,
   parameter int unsigned WR_LAT  = 1,
   parameter logic [7:0]  BASE_HI = 8'h80
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        AR_VALID,
   input  logic [31:0] AR_ADDR,
   output logic        AR_READY,
   output logic        R_VALID,
   output logic [31:0] R_DATA,
   output logic [1:0]  R_RESP,
   input  logic        R_READY,
   input  logic        AW_VALID,
   input  logic [31:0] AW_ADDR,
   output logic        AW_READY,
   input  logic        W_VALID,
   input  logic [31:0] W_DATA,
   output logic        W_READY,
   output logic        B_VALID,
   output logic [1:0]  B_RESP,
   input  logic        B_READY
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = 16;

   SLV_STATE         r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [IDX_W-1:0] r_idx, w_idx_nxt;
   logic [1:0]       r_resp, w_resp_nxt;
   logic             r_ar_ready, w_ar_ready_nxt;
   logic             r_aw_ready, w_aw_ready_nxt;
   logic             r_w_ready, w_w_ready_nxt;
   logic             r_r_valid, w_r_valid_nxt;
   logic [31:0]      r_r_data, w_r_data_nxt;
   logic [1:0]       r_r_resp, w_r_resp_nxt;
   logic             r_b_valid, w_b_valid_nxt;
   logic [1:0]       r_b_resp, w_b_resp_nxt;
   logic             w_mem_we;
   logic [31:0]      w_mem_rdata;

   axi_slave_mem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_mem (
      .clk       (clk),
      .i_we      (w_mem_we & ~rst),
      .i_addr    (r_idx),
      .i_wdata   (W_DATA),
      .o_rdata_c (w_mem_rdata)
   );

   // Next-state and registered-output logic; ready signals default low so they only pulse.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_idx_nxt      = r_idx;
      w_resp_nxt     = r_resp;
      w_ar_ready_nxt = 1'b0;
      w_aw_ready_nxt = 1'b0;
      w_w_ready_nxt  = 1'b0;
      w_r_valid_nxt  = r_r_valid;
      w_r_data_nxt   = r_r_data;
      w_r_resp_nxt   = r_r_resp;
      w_b_valid_nxt  = r_b_valid;
      w_b_resp_nxt   = r_b_resp;
      w_mem_we       = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (AR_VALID) begin
               w_ar_ready_nxt = 1'b1;
               w_state_nxt    = S_RD_LAT;
            end else if (AW_VALID) begin
               w_aw_ready_nxt = 1'b1;
               w_state_nxt    = S_WR_W;
            end
         end

         S_RD_LAT: begin
            if (r_ar_ready) begin
               w_idx_nxt  = IDX_W'(AR_ADDR >> 2);
               w_resp_nxt = decode_resp(AR_ADDR, BASE_HI, IDX_W);
               w_cnt_nxt  = CNT_W'(1);
            end else if (r_cnt == CNT_W'(RD_LAT)) begin
               w_state_nxt   = S_R;
               w_r_valid_nxt = 1'b1;
               w_r_resp_nxt  = r_resp;
               w_r_data_nxt  = (r_resp == RESP_OKAY) ? w_mem_rdata : 32'd0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end

         S_R: begin
            if (R_READY) begin
               w_r_valid_nxt = 1'b0;
               w_r_data_nxt  = 32'd0;
               w_r_resp_nxt  = RESP_OKAY;
               w_state_nxt   = S_IDLE;
            end
         end

         S_WR_W: begin
            if (r_aw_ready) begin
               w_idx_nxt  = IDX_W'(AW_ADDR >> 2);
               w_resp_nxt = decode_resp(AW_ADDR, BASE_HI, IDX_W);
            end
            // Decode was latched at the AW handshake, which always precedes this edge.
            if (r_w_ready) begin
               w_mem_we    = (r_resp == RESP_OKAY);
               w_cnt_nxt   = CNT_W'(1);
               w_state_nxt = S_WR_LAT;
            end else if (W_VALID) begin
               w_w_ready_nxt = 1'b1;
            end
         end

         S_WR_LAT: begin
            if (r_cnt == CNT_W'(WR_LAT)) begin
               w_state_nxt   = S_B;
               w_b_valid_nxt = 1'b1;
               w_b_resp_nxt  = r_resp;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end

         S_B: begin
            if (B_READY) begin
               w_b_valid_nxt = 1'b0;
               w_b_resp_nxt  = RESP_OKAY;
               w_state_nxt   = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_resp     <= RESP_OKAY;
         r_ar_ready <= 1'b0;
         r_aw_ready <= 1'b0;
         r_w_ready  <= 1'b0;
         r_r_valid  <= 1'b0;
         r_r_data   <= 32'd0;
         r_r_resp   <= RESP_OKAY;
         r_b_valid  <= 1'b0;
         r_b_resp   <= RESP_OKAY;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_idx      <= w_idx_nxt;
         r_resp     <= w_resp_nxt;
         r_ar_ready <= w_ar_ready_nxt;
         r_aw_ready <= w_aw_ready_nxt;
         r_w_ready  <= w_w_ready_nxt;
         r_r_valid  <= w_r_valid_nxt;
         r_r_data   <= w_r_data_nxt;
         r_r_resp   <= w_r_resp_nxt;
         r_b_valid  <= w_b_valid_nxt;
         r_b_resp   <= w_b_resp_nxt;
      end
   end

   assign AR_READY = r_ar_ready;
   assign AW_READY = r_aw_ready;
   assign W_READY  = r_w_ready;
   assign R_VALID  = r_r_valid;
   assign R_DATA   = r_r_data;
   assign R_RESP   = r_r_resp;
   assign B_VALID  = r_b_valid;
   assign B_RESP   = r_b_resp;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Scoreboard bench for axi_lite_mem_slave: drivers push expected R/B responses,
// a negedge monitor pops and compares them against a word-array reference.
module tb_axi_lite_mem_slave;

   localparam int unsigned DEPTH  = 256;
   localparam int unsigned RD_LAT = 2;
   localparam int unsigned WR_LAT = 1;
   localparam int          TMO    = 60;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      int          rise;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        AR_VALID, AR_READY, R_VALID, R_READY;
   logic [31:0] AR_ADDR, R_DATA;
   logic [1:0]  R_RESP;
   logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
   logic [31:0] AW_ADDR, W_DATA;
   logic [1:0]  B_RESP;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t rq[$];
   exp_t bq[$];
   logic [31:0] mdl [DEPTH];
   int   r_hs_cyc = 0;
   int   aw_seen_cyc = 0;

   axi_lite_mem_slave #(
      .DEPTH   (DEPTH),
      .RD_LAT  (RD_LAT),
      .WR_LAT  (WR_LAT),
      .BASE_HI (8'h80)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .AR_VALID (AR_VALID),
      .AR_ADDR  (AR_ADDR),
      .AR_READY (AR_READY),
      .R_VALID  (R_VALID),
      .R_DATA   (R_DATA),
      .R_RESP   (R_RESP),
      .R_READY  (R_READY),
      .AW_VALID (AW_VALID),
      .AW_ADDR  (AW_ADDR),
      .AW_READY (AW_READY),
      .W_VALID  (W_VALID),
      .W_DATA   (W_DATA),
      .W_READY  (W_READY),
      .B_VALID  (B_VALID),
      .B_RESP   (B_RESP),
      .B_READY  (B_READY)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h @cyc %0d", name, act, exp, cyc);
      end
   endtask

   task automatic tmo_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s act=timeout exp=handshake @cyc %0d", name, cyc);
   endtask

   // Response rule written directly from the address map.
   function automatic logic [1:0] exp_resp(input logic [31:0] a);
      if (a[31:24] != 8'h80) return 2'b10;
      if (a[23:0] >= 24'(DEPTH * 4)) return 2'b11;
      return 2'b00;
   endfunction

   function automatic int exp_idx(input logic [31:0] a);
      return int'(a[23:0]) / 4;
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      int k;
      k = $urandom_range(0, 9);
      a = {8'h80, 24'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3))};
      if (k == 0) a[31:24] = 8'($urandom_range(0, 255));
      else if (k == 1) a[23:0] = 24'($urandom) | 24'(DEPTH * 4);
      return a;
   endfunction

   task automatic do_read(input logic [31:0] a, input int rhold);
      int n;
      exp_t e;
      @(negedge clk);
      AR_VALID = 1'b1;
      AR_ADDR  = a;
      n = 0;
      while (!AR_READY && n < TMO) begin @(negedge clk); n++; end
      if (!AR_READY) begin tmo_fail("ar_ready"); AR_VALID = 1'b0; return; end
      e.resp = exp_resp(a);
      e.data = (e.resp == 2'b00) ? mdl[exp_idx(a)] : 32'd0;
      e.rise = cyc + 1 + RD_LAT;
      rq.push_back(e);
      @(negedge clk);
      AR_VALID = 1'b0;
      n = 0;
      while (!R_VALID && n < TMO) begin @(negedge clk); n++; end
      if (!R_VALID) begin tmo_fail("r_valid"); return; end
      repeat (rhold) @(negedge clk);
      R_READY  = 1'b1;
      r_hs_cyc = cyc + 1;
      @(negedge clk);
      R_READY = 1'b0;
      chk("r_valid_drop", 64'(R_VALID), 64'd0);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int wdel, input int bhold);
      int n;
      exp_t e;
      @(negedge clk);
      AW_VALID = 1'b1;
      AW_ADDR  = a;
      W_DATA   = d;
      W_VALID  = (wdel == 0);
      n = 0;
      while (!AW_READY && n < TMO) begin @(negedge clk); n++; end
      if (!AW_READY) begin tmo_fail("aw_ready"); AW_VALID = 1'b0; W_VALID = 1'b0; return; end
      aw_seen_cyc = cyc;
      @(negedge clk);
      AW_VALID = 1'b0;
      if (wdel > 0) begin
         repeat (wdel - 1) @(negedge clk);
         W_VALID = 1'b1;
      end
      n = 0;
      while (!W_READY && n < TMO) begin @(negedge clk); n++; end
      if (!W_READY) begin tmo_fail("w_ready"); W_VALID = 1'b0; return; end
      e.resp = exp_resp(a);
      e.data = 32'd0;
      e.rise = cyc + 1 + WR_LAT;
      bq.push_back(e);
      if (e.resp == 2'b00) mdl[exp_idx(a)] = d;
      @(negedge clk);
      W_VALID = 1'b0;
      n = 0;
      while (!B_VALID && n < TMO) begin @(negedge clk); n++; end
      if (!B_VALID) begin tmo_fail("b_valid"); return; end
      repeat (bhold) @(negedge clk);
      B_READY = 1'b1;
      @(negedge clk);
      B_READY = 1'b0;
   endtask

   // Monitor: pops expected responses when R/B valid rise, checks hold and invariants.
   logic        prev_rv, prev_bv, prev_ar, prev_aw, prev_w;
   logic [33:0] held_r;
   logic [1:0]  held_b;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_rv = 1'b0; prev_bv = 1'b0;
         prev_ar = 1'b0; prev_aw = 1'b0; prev_w = 1'b0;
      end else begin
         if (R_VALID && !prev_rv) begin
            if (rq.size() == 0) begin
               chk("r_unexpected", 64'(R_VALID), 64'd0);
            end else begin
               e = rq.pop_front();
               chk("r_data", 64'(R_DATA), 64'(e.data));
               chk("r_resp", 64'(R_RESP), 64'(e.resp));
               chk("r_latency", 64'(cyc), 64'(e.rise));
            end
            held_r = {R_RESP, R_DATA};
         end else if (R_VALID) begin
            chk("r_stable", 64'({R_RESP, R_DATA}), 64'(held_r));
         end
         if (B_VALID && !prev_bv) begin
            if (bq.size() == 0) begin
               chk("b_unexpected", 64'(B_VALID), 64'd0);
            end else begin
               e = bq.pop_front();
               chk("b_resp", 64'(B_RESP), 64'(e.resp));
               chk("b_latency", 64'(cyc), 64'(e.rise));
            end
            held_b = B_RESP;
         end else if (B_VALID) begin
            chk("b_stable", 64'(B_RESP), 64'(held_b));
         end
         chk("invariants",
             64'({R_VALID & B_VALID,
                  32'($countones({AR_READY, AW_READY, W_READY})) > 32'd1,
                  (AR_READY & prev_ar) | (AW_READY & prev_aw) | (W_READY & prev_w)}),
             64'd0);
         prev_rv = R_VALID; prev_bv = B_VALID;
         prev_ar = AR_READY; prev_aw = AW_READY; prev_w = W_READY;
      end
   end

   initial begin
      logic [40:0] outs;
      rst = 1'b1;
      AR_VALID = 1'b0; AR_ADDR = 32'd0; R_READY = 1'b0;
      AW_VALID = 1'b0; AW_ADDR = 32'd0; W_VALID = 1'b0; W_DATA = 32'd0; B_READY = 1'b0;
      repeat (3) @(negedge clk);
      outs = {AR_READY, AW_READY, W_READY, R_VALID, B_VALID, R_RESP, B_RESP, R_DATA};
      chk("reset_outputs", 64'(outs), 64'd0);
      rst = 1'b0;

      // Fill every word so later reads have defined expectations.
      for (int i = 0; i < int'(DEPTH); i++)
         do_write({8'h80, 24'(i * 4)}, $urandom, 0, 0);

      do_write(32'h8000_0010, 32'hDEADBEEF, 0, 0);
      do_read(32'h8000_0010, 0);

      do_read(32'h0000_0010, 1);
      do_write(32'h0000_0010, 32'h1234_5678, 1, 0);
      do_read(32'h8000_0010, 0);

      do_write(32'h8000_0400, 32'h5555_AAAA, 0, 2);
      do_read(32'h8000_0000, 0);

      do_read(32'h8000_0010, 5);

      // AR and AW presented together: the read must finish before AW_READY.
      fork
         do_read(32'h8000_0020, 2);
         do_write(32'h8000_0030, 32'h0BAD_F00D, 0, 0);
      join
      chk("aw_after_read", 64'(aw_seen_cyc > r_hs_cyc), 64'd1);
      do_read(32'h8000_0030, 0);

      // Reset lands on the W handshake edge: the write must not land.
      @(negedge clk);
      AW_VALID = 1'b1; AW_ADDR = 32'h8000_0020; W_VALID = 1'b1; W_DATA = 32'hCAFE0000;
      begin
         int n;
         n = 0;
         while (!AW_READY && n < TMO) begin @(negedge clk); n++; end
         if (!AW_READY) tmo_fail("rst_aw_ready");
      end
      @(negedge clk);
      rst = 1'b1; AW_VALID = 1'b0;
      @(negedge clk);
      rst = 1'b0; W_VALID = 1'b0;
      outs = {AR_READY, AW_READY, W_READY, R_VALID, B_VALID, R_RESP, B_RESP, R_DATA};
      chk("midop_reset_outputs", 64'(outs), 64'd0);
      do_read(32'h8000_0020, 0);

      for (int k = 0; k < 150; k++) begin
         if ($urandom_range(0, 1) == 0)
            do_read(rand_addr(), $urandom_range(0, 3));
         else
            do_write(rand_addr(), $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      repeat (5) @(negedge clk);
      chk("rq_drained", 64'(rq.size()), 64'd0);
      chk("bq_drained", 64'(bq.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
